mult_share_arbiter: RTL

//  Shares one pipelined unsigned multiplier between NREQ requesters. Grants round-robin, at most one issue per cycle.

---
 rtl/mult_share_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/mult_share_arbiter.sv
// Round-robin sharing of one pipelined unsigned multiplier among NREQ requesters.
// Each requester owns one result slot; a tag pipe routes every product back to its owner.
module mult_share_arbiter #(
  parameter int BW      = 16,
  parameter int NREQ    = 4,
  parameter int MUL_LAT = 1,
  localparam int PW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*BW-1:0]     req_a,
  input  logic [NREQ*BW-1:0]     req_b,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [NREQ*2*BW-1:0]   rsp_data,
  input  logic [NREQ-1:0]        rsp_ready,
  output logic [BW-1:0]          mul_a,
  output logic [BW-1:0]          mul_b,
  input  logic [2*BW-1:0]        mul_out,
  output logic                   busy,
  output logic [2*NREQ-1:0]      dbg_slot_state,
  output logic [PW-1:0]          dbg_ptr
);
  // Handshakes: a request transfers on an edge where req_valid[i] & req_ready[i];
  // a result transfers on an edge where rsp_valid[i] & rsp_ready[i].
  localparam int NST = MUL_LAT + 1;

  typedef enum logic [1:0] {
    SLOT_IDLE = 2'd0,
    SLOT_PEND = 2'd1,
    SLOT_DONE = 2'd2
  } slot_e;

  slot_e           slot_q     [NREQ];
  slot_e           slot_d     [NREQ];
  logic [2*BW-1:0] rsp_data_q [NREQ];
  logic [2*BW-1:0] rsp_data_d [NREQ];
  logic [PW-1:0]   tag_id_q   [NST];
  logic [PW-1:0]   tag_id_d   [NST];
  logic [NST-1:0]  tag_vld_q, tag_vld_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [BW-1:0]   mul_a_q, mul_a_d;
  logic [BW-1:0]   mul_b_q, mul_b_d;

  logic [NREQ-1:0] eligible;
  logic            gnt_vld;
  logic [PW-1:0]   gnt_idx;
  logic [PW:0]     cand_sum;
  logic [PW-1:0]   cand;
  logic [PW-1:0]   cap_id;

  // Round-robin search starting at ptr; first eligible requester wins.
  always_comb begin
    gnt_vld   = 1'b0;
    gnt_idx   = '0;
    cand_sum  = '0;
    cand      = '0;
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      eligible[i] = req_valid[i] && (slot_q[i] == SLOT_IDLE);
    end
    for (int k = 0; k < NREQ; k++) begin
      cand_sum = {1'b0, ptr_q} + (PW+1)'(k);
      if (cand_sum >= (PW+1)'(NREQ)) cand_sum = cand_sum - (PW+1)'(NREQ);
      cand = cand_sum[PW-1:0];
      if (!gnt_vld && eligible[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
    if (gnt_vld) req_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    ptr_d     = ptr_q;
    mul_a_d   = mul_a_q;
    mul_b_d   = mul_b_q;
    tag_vld_d = {tag_vld_q[NST-2:0], gnt_vld};
    tag_id_d[0] = gnt_idx;
    for (int s = 1; s < NST; s++) tag_id_d[s] = tag_id_q[s-1];
    cap_id = tag_id_q[NST-1];
    for (int i = 0; i < NREQ; i++) begin
      slot_d[i]     = slot_q[i];
      rsp_data_d[i] = rsp_data_q[i];
      if (slot_q[i] == SLOT_DONE && rsp_ready[i]) slot_d[i] = SLOT_IDLE;
      if (gnt_vld && gnt_idx == PW'(i)) begin
        slot_d[i] = SLOT_PEND;
        mul_a_d   = req_a[i*BW +: BW];
        mul_b_d   = req_b[i*BW +: BW];
      end
      // Final tag stage lines up with mul_out holding that op's product.
      if (tag_vld_q[NST-1] && cap_id == PW'(i)) begin
        slot_d[i]     = SLOT_DONE;
        rsp_data_d[i] = mul_out;
      end
    end
    if (gnt_vld) ptr_d = (gnt_idx == PW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      ptr_q     <= '0;
      mul_a_q   <= '0;
      mul_b_q   <= '0;
      tag_vld_q <= '0;
      for (int s = 0; s < NST; s++) tag_id_q[s] <= '0;
      for (int i = 0; i < NREQ; i++) begin
        slot_q[i]     <= SLOT_IDLE;
        rsp_data_q[i] <= '0;
      end
    end else begin
      ptr_q     <= ptr_d;
      mul_a_q   <= mul_a_d;
      mul_b_q   <= mul_b_d;
      tag_vld_q <= tag_vld_d;
      for (int s = 0; s < NST; s++) tag_id_q[s] <= tag_id_d[s];
      for (int i = 0; i < NREQ; i++) begin
        slot_q[i]     <= slot_d[i];
        rsp_data_q[i] <= rsp_data_d[i];
      end
    end
  end

  always_comb begin
    busy = |tag_vld_q;
    for (int i = 0; i < NREQ; i++) begin
      rsp_valid[i]                   = (slot_q[i] == SLOT_DONE);
      rsp_data[i*2*BW +: 2*BW]       = rsp_data_q[i];
      dbg_slot_state[2*i +: 2]       = slot_q[i];
      if (slot_q[i] != SLOT_IDLE) busy = 1'b1;
    end
  end

  assign mul_a   = mul_a_q;
  assign mul_b   = mul_b_q;
  assign dbg_ptr = ptr_q;

endmodule
